// File: rtl/move_controller.sv
// move_controller: turn-based move sequencer in front of figure_move_logic.
// Owns the board and turn flag, captures source/destination clicks, waits for
// the legal-move mask and commits legal moves (capture, promotion, game over).
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | nothing selected, waiting for a click on an own piece
//  WAIT_MASK | source latched, waiting for possible_moves to settle
//  DEST      | mask valid, waiting for the destination click
//  OVER      | a king was captured; frozen until rst
module move_controller #(
   parameter int MASK_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  click_valid,
   input  logic [5:0]            click_pos,
   input  logic [63:0]           possible_moves,
   output logic [7:0][7:0][3:0]  board,
   output logic [3:0]            selected_figure,
   output logic [5:0]            position,
   output logic                  sel_active,
   output logic                  turn,
   output logic                  move_done,
   output logic                  capture,
   output logic                  illegal,
   output logic                  game_over,
   output logic                  winner
);

   localparam int CW = (MASK_LATENCY < 2) ? 1 : $clog2(MASK_LATENCY + 1);

   typedef enum logic [1:0] {IDLE, WAIT_MASK, DEST, OVER} state_t;

   state_t                 state, nxt_state;
   logic [CW-1:0]          cnt, nxt_cnt;
   logic [7:0][7:0][3:0]   nxt_board;
   logic [3:0]             nxt_sel;
   logic [5:0]             nxt_pos;
   logic                   nxt_turn, nxt_done, nxt_cap, nxt_ill, nxt_go, nxt_win;
   logic [3:0]             click_fig, moved_fig;
   logic                   own_piece;

   // Starting position, row 0 (black back rank) at the top.
   function automatic logic [7:0][7:0][3:0] init_board();
      logic [7:0][7:0][3:0] b;
      b = '0;
      for (int c = 0; c < 8; c++) begin
         b[1][c] = 4'd7;
         b[6][c] = 4'd1;
      end
      b[0][0] = 4'd8;  b[0][1] = 4'd9;  b[0][2] = 4'd10; b[0][3] = 4'd11;
      b[0][4] = 4'd12; b[0][5] = 4'd10; b[0][6] = 4'd9;  b[0][7] = 4'd8;
      b[7][0] = 4'd2;  b[7][1] = 4'd3;  b[7][2] = 4'd4;  b[7][3] = 4'd5;
      b[7][4] = 4'd6;  b[7][5] = 4'd4;  b[7][6] = 4'd3;  b[7][7] = 4'd2;
      return b;
   endfunction

   // Decode the clicked square and the figure as it would land there.
   always_comb begin
      click_fig = board[click_pos[5:3]][click_pos[2:0]];
      own_piece = turn ? (click_fig >= 4'd7 && click_fig <= 4'd12)
                       : (click_fig >= 4'd1 && click_fig <= 4'd6);
      moved_fig = selected_figure;
      if (selected_figure == 4'd1 && click_pos[5:3] == 3'd0)
         moved_fig = 4'd5;
      else if (selected_figure == 4'd7 && click_pos[5:3] == 3'd7)
         moved_fig = 4'd11;
   end

   // Next-state and next-output logic.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_board = board;
      nxt_sel   = selected_figure;
      nxt_pos   = position;
      nxt_turn  = turn;
      nxt_done  = 1'b0;
      nxt_cap   = 1'b0;
      nxt_ill   = 1'b0;
      nxt_go    = game_over;
      nxt_win   = winner;
      case (state)
         IDLE: begin
            if (click_valid) begin
               if (own_piece) begin
                  nxt_pos   = click_pos;
                  nxt_sel   = click_fig;
                  nxt_cnt   = CW'(MASK_LATENCY);
                  nxt_state = WAIT_MASK;
               end else begin
                  nxt_ill = 1'b1;
               end
            end
         end
         WAIT_MASK: begin
            // Clicks are dropped here; the mask is not yet trustworthy.
            if (cnt <= CW'(1)) begin
               nxt_cnt   = '0;
               nxt_state = DEST;
            end else begin
               nxt_cnt = cnt - CW'(1);
            end
         end
         DEST: begin
            if (click_valid) begin
               if (click_pos == position) begin
                  nxt_sel   = 4'd0;
                  nxt_state = IDLE;
               end else if (own_piece) begin
                  nxt_pos   = click_pos;
                  nxt_sel   = click_fig;
                  nxt_cnt   = CW'(MASK_LATENCY);
                  nxt_state = WAIT_MASK;
               end else if (possible_moves[6'd63 - click_pos]) begin
                  nxt_board[position[5:3]][position[2:0]]   = 4'd0;
                  nxt_board[click_pos[5:3]][click_pos[2:0]] = moved_fig;
                  nxt_cap  = (click_fig != 4'd0);
                  nxt_done = 1'b1;
                  nxt_sel  = 4'd0;
                  if (click_fig == 4'd6 || click_fig == 4'd12) begin
                     nxt_go    = 1'b1;
                     nxt_win   = turn;
                     nxt_state = OVER;
                  end else begin
                     nxt_turn  = ~turn;
                     nxt_state = IDLE;
                  end
               end else begin
                  nxt_ill = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // State and output registers; rst wins over any click.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         board           <= init_board();
         selected_figure <= 4'd0;
         position        <= 6'd0;
         sel_active      <= 1'b0;
         turn            <= 1'b0;
         move_done       <= 1'b0;
         capture         <= 1'b0;
         illegal         <= 1'b0;
         game_over       <= 1'b0;
         winner          <= 1'b0;
      end else begin
         state           <= nxt_state;
         cnt             <= nxt_cnt;
         board           <= nxt_board;
         selected_figure <= nxt_sel;
         position        <= nxt_pos;
         sel_active      <= (nxt_state == WAIT_MASK) || (nxt_state == DEST);
         turn            <= nxt_turn;
         move_done       <= nxt_done;
         capture         <= nxt_cap;
         illegal         <= nxt_ill;
         game_over       <= nxt_go;
         winner          <= nxt_win;
      end
   end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: a scripted game with hand-tracked board.
module tb_move_controller;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  click_valid = 1'b0;
   logic [5:0]            click_pos = 6'd0;
   logic [63:0]           possible_moves = 64'd0;
   logic [7:0][7:0][3:0]  board;
   logic [3:0]            selected_figure;
   logic [5:0]            position;
   logic                  sel_active, turn, move_done, capture, illegal, game_over, winner;

   logic [7:0][7:0][3:0]  exp_board, init_b;
   int                    vectors = 0;
   int                    miscompares = 0;

   move_controller #(.MASK_LATENCY(2)) dut (
      .clk(clk), .rst(rst), .click_valid(click_valid), .click_pos(click_pos),
      .possible_moves(possible_moves), .board(board),
      .selected_figure(selected_figure), .position(position),
      .sel_active(sel_active), .turn(turn), .move_done(move_done),
      .capture(capture), .illegal(illegal), .game_over(game_over),
      .winner(winner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [63:0] bit_for(input logic [5:0] p);
      return 64'd1 << (63 - int'(p));
   endfunction

   // All tasks start and end at a falling edge; a click spans one rising edge.
   task automatic click(input logic [5:0] p);
      click_valid = 1'b1;
      click_pos   = p;
      @(negedge clk);
      click_valid = 1'b0;
   endtask

   task automatic do_move(input logic [5:0] src, input logic [5:0] dst);
      possible_moves = bit_for(dst);
      click(src);
      repeat (2) @(negedge clk);
      click(dst);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " board"}, board, init_b);
      chk({tag, " sel_fig"}, selected_figure, 4'd0);
      chk({tag, " position"}, position, 6'd0);
      chk({tag, " sel_active"}, sel_active, 1'b0);
      chk({tag, " turn"}, turn, 1'b0);
      chk({tag, " pulses"}, {move_done, capture, illegal}, 3'b000);
      chk({tag, " game_over"}, {game_over, winner}, 2'b00);
   endtask

   initial begin
      init_b = '0;
      for (int c = 0; c < 8; c++) begin
         init_b[1][c] = 4'd7;
         init_b[6][c] = 4'd1;
      end
      init_b[0][0] = 4'd8;  init_b[0][1] = 4'd9;  init_b[0][2] = 4'd10; init_b[0][3] = 4'd11;
      init_b[0][4] = 4'd12; init_b[0][5] = 4'd10; init_b[0][6] = 4'd9;  init_b[0][7] = 4'd8;
      init_b[7][0] = 4'd2;  init_b[7][1] = 4'd3;  init_b[7][2] = 4'd4;  init_b[7][3] = 4'd5;
      init_b[7][4] = 4'd6;  init_b[7][5] = 4'd4;  init_b[7][6] = 4'd3;  init_b[7][7] = 4'd2;
      exp_board = init_b;

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("reset");

      // Opponent piece and empty square rejected while white to move.
      click(6'o10);
      chk("opp illegal", illegal, 1'b1);
      chk("opp sel_active", sel_active, 1'b0);
      @(negedge clk);
      chk("opp illegal gone", illegal, 1'b0);
      click(6'o30);
      chk("empty illegal", illegal, 1'b1);

      // Select, click dropped in WAIT_MASK, rejected destination, deselect.
      possible_moves = 64'd0;
      click(6'o60);
      chk("sel fig", selected_figure, 4'd1);
      chk("sel pos", position, 6'o60);
      chk("sel active", sel_active, 1'b1);
      click(6'o30);
      chk("wait drop illegal", illegal, 1'b0);
      chk("wait drop active", sel_active, 1'b1);
      @(negedge clk);
      click(6'o30);
      chk("mask clr illegal", illegal, 1'b1);
      chk("mask clr active", sel_active, 1'b1);
      click(6'o60);
      chk("desel active", sel_active, 1'b0);
      chk("desel fig", selected_figure, 4'd0);
      chk("desel illegal", illegal, 1'b0);

      // White pawn double step with two mask bits set.
      possible_moves = bit_for(6'o50) | bit_for(6'o40);
      click(6'o60);
      repeat (2) @(negedge clk);
      click(6'o40);
      exp_board[4][0] = 4'd1; exp_board[6][0] = 4'd0;
      chk("m1 board", board, exp_board);
      chk("m1 turn", turn, 1'b1);
      chk("m1 done/cap", {move_done, capture}, 2'b10);
      chk("m1 sel cleared", {sel_active, selected_figure}, 5'd0);
      @(negedge clk);
      chk("m1 pulse end", move_done, 1'b0);

      // Black: select 11, reselect 17 in DEST, move 17->37.
      possible_moves = bit_for(6'o37);
      click(6'o11);
      repeat (2) @(negedge clk);
      click(6'o17);
      chk("resel pos", position, 6'o17);
      chk("resel fig", selected_figure, 4'd7);
      chk("resel active", sel_active, 1'b1);
      repeat (2) @(negedge clk);
      click(6'o37);
      exp_board[3][7] = 4'd7; exp_board[1][7] = 4'd0;
      chk("m2 board", board, exp_board);
      chk("m2 turn", turn, 1'b0);

      // White 61->11 captures the black pawn.
      do_move(6'o61, 6'o11);
      exp_board[1][1] = 4'd1; exp_board[6][1] = 4'd0;
      chk("m3 board", board, exp_board);
      chk("m3 done/cap", {move_done, capture}, 2'b11);
      @(negedge clk);
      chk("m3 pulse end", {move_done, capture}, 2'b00);

      do_move(6'o37, 6'o47);
      exp_board[4][7] = 4'd7; exp_board[3][7] = 4'd0;
      chk("m4 board", board, exp_board);

      // White pawn takes the rook on row 0 and promotes.
      do_move(6'o11, 6'o00);
      exp_board[0][0] = 4'd5; exp_board[1][1] = 4'd0;
      chk("promo board", board, exp_board);
      chk("promo cap", capture, 1'b1);
      chk("promo turn", turn, 1'b1);

      do_move(6'o47, 6'o57);
      exp_board[5][7] = 4'd7; exp_board[4][7] = 4'd0;
      chk("m6 board", board, exp_board);

      // Queen captures the black king.
      do_move(6'o00, 6'o04);
      exp_board[0][4] = 4'd5; exp_board[0][0] = 4'd0;
      chk("ko board", board, exp_board);
      chk("ko over/winner", {game_over, winner}, 2'b10);
      chk("ko done/cap", {move_done, capture}, 2'b11);
      chk("ko turn kept", turn, 1'b0);

      // Frozen in OVER.
      possible_moves = ~64'd0;
      click(6'o62);
      chk("over illegal", {illegal, move_done, sel_active}, 3'b000);
      click(6'o10);
      repeat (3) @(negedge clk);
      click(6'o52);
      chk("over pulses", {illegal, move_done, capture, sel_active}, 4'b0000);
      chk("over board", board, exp_board);
      chk("over sticky", game_over, 1'b1);

      pulse_rst();
      chk_reset_vals("rst after over");

      // Reset in DEST overrides a simultaneous legal destination click.
      possible_moves = bit_for(6'o57);
      click(6'o67);
      click(6'o57);
      chk("early click drop", {sel_active, illegal, move_done}, 3'b100);
      @(negedge clk);
      rst = 1'b1;
      click_valid = 1'b1;
      click_pos = 6'o57;
      @(negedge clk);
      rst = 1'b0;
      click_valid = 1'b0;
      chk_reset_vals("rst in dest");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
